// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and width helpers for the matrix-multiply controller.
// Holds the controller state encoding, the default matrix size and the
// functions that derive address/index widths from N.
package matmul_pkg;

  // Controller states, in the order a run walks through them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_MAC    = 3'd4,
    ST_STORE  = 3'd5,
    ST_OUT    = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam int DEFAULT_N = 3;

  // Operand memory holds A then B, 2*N*N words.
  function automatic int calc_aw(input int n);
    return $clog2(2 * n * n);
  endfunction

  // row/col/k index width, never narrower than one bit.
  function automatic int calc_iw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Buffer / result index width, never narrower than one bit.
  function automatic int calc_cw(input int n);
    int w;
    w = $clog2(n * n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// matmul_idx_cnt: modulo counter 0..MAX with synchronous clear and enable.
// 'last' flags the terminal value so the caller can chain or change state;
// an enabled count at the terminal value wraps to zero.
module matmul_idx_cnt #(
  parameter int W   = 2,
  parameter int MAX = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign last = (cnt == MAX_V);

  // Count register: clear wins over enable, wrap at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencer for an NxN matrix multiply.
// A run loads A (addresses 0..N*N-1) and B (N*N..2*N*N-1) into operand
// buffers, then for each result element issues N accumulate cycles followed
// by one store cycle, then streams the result indices out and pulses done.
// Build macro MATMUL_CTRL_ABORT_EN adds an 'abort' input that drops any run
// back to IDLE without a done pulse.
//
// Result stream handshake: a transfer occurs on a rising clk edge where
// out_valid and out_ready are both high; while out_ready is low, out_valid
// stays high and out_idx is held.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int AW = calc_aw(N),
  parameter int IW = calc_iw(N),
  parameter int CW = calc_cw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef MATMUL_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          a_we,
  output logic          b_we,
  output logic [CW-1:0] buf_idx,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic [IW-1:0] k,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          c_we,
  output logic [CW-1:0] c_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output state_t        state_dbg
);

  state_t state, state_n;

  logic cnt_clr;
  logic buf_en, k_en, col_en, row_en, out_en;
  logic buf_last, k_last, col_last, row_last, out_last;

  logic [CW-1:0] buf_cnt, out_cnt;
  logic [IW-1:0] row_cnt, col_cnt, k_cnt;

  // Operand buffer index, shared by the A and B load phases.
  matmul_idx_cnt #(.W(CW), .MAX(N*N-1)) u_buf_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(buf_en), .cnt(buf_cnt), .last(buf_last)
  );

  // Dot-product step within one result element.
  matmul_idx_cnt #(.W(IW), .MAX(N-1)) u_k_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(k_en), .cnt(k_cnt), .last(k_last)
  );

  // Result column; advances once per store.
  matmul_idx_cnt #(.W(IW), .MAX(N-1)) u_col_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(col_en), .cnt(col_cnt), .last(col_last)
  );

  // Result row; advances when the column wraps.
  matmul_idx_cnt #(.W(IW), .MAX(N-1)) u_row_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(row_en), .cnt(row_cnt), .last(row_last)
  );

  // Result stream index; advances only on a completed handshake.
  matmul_idx_cnt #(.W(CW), .MAX(N*N-1)) u_out_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(out_en), .cnt(out_cnt), .last(out_last)
  );

  assign buf_idx   = buf_cnt;
  assign row       = row_cnt;
  assign col       = col_cnt;
  assign k         = k_cnt;
  assign out_idx   = out_cnt;
  assign c_idx     = CW'(row_cnt) * CW'(N) + CW'(col_cnt);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, strobes and counter enables for the current state.
  always_comb begin
    state_n   = state;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    a_we      = 1'b0;
    b_we      = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    c_we      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    buf_en    = 1'b0;
    k_en      = 1'b0;
    col_en    = 1'b0;
    row_en    = 1'b0;
    out_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_INIT;
      end
      ST_INIT: begin
        acc_clr = 1'b1;
        cnt_clr = 1'b1;
        state_n = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        mem_rd_en = 1'b1;
        a_we      = 1'b1;
        mem_addr  = AW'(buf_cnt);
        buf_en    = 1'b1;
        if (buf_last) state_n = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        mem_rd_en = 1'b1;
        b_we      = 1'b1;
        mem_addr  = AW'(buf_cnt) + AW'(N*N);
        buf_en    = 1'b1;
        if (buf_last) state_n = ST_MAC;
      end
      ST_MAC: begin
        acc_en = 1'b1;
        k_en   = 1'b1;
        if (k_last) state_n = ST_STORE;
      end
      ST_STORE: begin
        // The accumulator clear lands on the edge that ends this cycle,
        // after the result has been written.
        c_we    = 1'b1;
        acc_clr = 1'b1;
        col_en  = 1'b1;
        row_en  = col_last;
        state_n = (row_last && col_last) ? ST_OUT : ST_MAC;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        out_en    = out_ready;
        if (out_ready && out_last) state_n = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

`ifdef MATMUL_CTRL_ABORT_EN
    // Abort overrides everything: no writes, no stream beat, no done.
    if (abort && (state != ST_IDLE)) begin
      state_n   = ST_IDLE;
      cnt_clr   = 1'b1;
      mem_addr  = '0;
      mem_rd_en = 1'b0;
      a_we      = 1'b0;
      b_we      = 1'b0;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;
      c_we      = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      buf_en    = 1'b0;
      k_en      = 1'b0;
      col_en    = 1'b0;
      row_en    = 1'b0;
      out_en    = 1'b0;
    end
`endif
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameter N, default 3: square matrix dimension; legal range 2..16.
REQ-002 Parameter AW, default $clog2(2*N*N): operand memory address width.
REQ-003 Parameter IW, default $clog2(N) (minimum 1): row/col/k index width.
REQ-004 Parameter CW, default $clog2(N*N) (minimum 1): buffer/result index width.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 start  input  1  run request, level-sampled in IDLE.
REQ-008 mem_addr  output  AW  operand memory address; memory read is combinational.
REQ-009 mem_rd_en  output  1  memory read strobe.
REQ-010 a_we / b_we  output  1 each  write enables of A / B operand buffers.
REQ-011 buf_idx  output  CW  A/B buffer write index.
REQ-012 row, col, k  output  IW each  operand select: A[row][k], B[k][col].
REQ-013 acc_clr / acc_en  output  1 each  accumulator clear / accumulate.
REQ-014 c_we  output  1  result buffer write; c_idx  output  CW  = row*N+col.
REQ-015 out_valid  output  1; out_ready  input  1; out_idx  output  CW  result streaming handshake.
REQ-016 busy  output  1  high in every state except IDLE; done  output  1  completion pulse.

Function
REQ-017 States: IDLE, INIT, LOAD_A, LOAD_B, MAC, STORE, OUT, DONE.
REQ-018 IDLE: all strobes 0; start=1 moves to INIT next edge; start in any other state is ignored.
REQ-019 INIT (1 cycle): acc_clr=1; all counters cleared; next state LOAD_A.
REQ-020 LOAD_A (N*N cycles): mem_rd_en=1, a_we=1, mem_addr=0..N*N-1, buf_idx=mem_addr; after address N*N-1, next state LOAD_B.
REQ-021 LOAD_B (N*N cycles): mem_rd_en=1, b_we=1, mem_addr=N*N..2*N*N-1, buf_idx=mem_addr-N*N; after the last address, next state MAC.
REQ-022 MAC (N cycles per element): acc_en=1; k increments 0..N-1; at k=N-1, next state STORE with k wrapping to 0.
REQ-023 STORE (1 cycle): c_we=1 at c_idx; acc_clr=1 in the same cycle (the clear takes effect at the edge ending STORE).
REQ-024 STORE advance: col+1; at col=N-1, col wraps to 0 and row increments.
REQ-025 STORE exit: at row=N-1 and col=N-1, next state OUT; otherwise next state MAC.
REQ-026 Compute latency from start acceptance to first out_valid: 1 + 2*N*N + N*N*(N+1) cycles (N=3: 55).
REQ-027 OUT: out_valid=1; out_idx starts at 0 and advances only on out_valid&out_ready; out_ready low stalls with out_idx held.
REQ-028 OUT exit: the handshake at out_idx=N*N-1 moves to DONE.
REQ-029 DONE (1 cycle): done=1; next state IDLE; start still high then begins a new run one cycle later.
REQ-030 All counters are modular and never exceed N-1 (or N*N-1 for index counters); no strobe is asserted outside its state.

Reset
REQ-031 While rst is high: state=IDLE; all counters=0; every output=0, asynchronously.
REQ-032 Reset mid-run abandons the run: no done pulse; the next run starts from INIT.

Configuration
REQ-033 Macro MATMUL_CTRL_ABORT_EN defined: adds input abort (1 bit).
REQ-034 With the macro: abort=1 in any non-IDLE state forces next state IDLE, clears counters, and forces a_we/b_we/c_we/out_valid to 0 in that cycle; no done pulse.
REQ-035 Without the macro: no abort port; every accepted run completes.

Structure
REQ-036 Shared package matmul_pkg: state enum typedef, default N, and width constant functions (AW/IW/CW derivation).
REQ-037 One sub-module matmul_idx_cnt (parametrised modulo counter with clr, en, last flag) is instantiated for row, col, k and the index counters.

Verification
REQ-038 N=3, start pulse, out_ready=1: a_we high for cycles 2-10 (addr 0-8); b_we high for cycles 11-19 (addr 9-17); 9 c_we pulses; first out_valid at cycle 56; done pulses once.
REQ-039 N=2: sequence row,col,k = (0,0,0),(0,0,1),STORE,(0,1,0)... with c_idx 0,1,2,3; total compute latency 21 cycles.
REQ-040 OUT with out_ready toggling 1,0,0,1: out_idx holds through the 0 cycles; exactly N*N handshakes occur before DONE.
REQ-041 start asserted during MAC: ignored, no counter disturbance; start held through DONE starts a new INIT one cycle after IDLE.
REQ-042 rst asserted in LOAD_B at addr 12: all outputs go 0 immediately; after release, start gives a clean run from addr 0.
REQ-043 With MATMUL_CTRL_ABORT_EN, abort asserted in STORE: no c_we in that cycle, IDLE next, done never asserted.
